// File: rtl/cprv_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : cprv_writeback_if
// Purpose  : Bundle of the execute/load result streams, the register-file
//            write port and the forwarding bus of the writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
interface cprv_writeback_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
);
   // execute result stream
   logic                  ex_valid;
   logic                  ex_ready;
   logic [ADDR_WIDTH-1:0] ex_rd_addr;
   logic [DATA_WIDTH-1:0] ex_data;
   logic                  ex_word;
   // load result stream
   logic                  mem_valid;
   logic                  mem_ready;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [1:0]            mem_size;
   logic                  mem_unsigned;
   logic [2:0]            mem_byte_off;
   // register-file write port
   logic [ADDR_WIDTH-1:0] rf_rd_addr;
   logic                  rf_rd_en;
   logic [DATA_WIDTH-1:0] rf_rd_data;
   // same-cycle forwarding bus
   logic                  fwd_valid;
   logic [ADDR_WIDTH-1:0] fwd_addr;
   logic [DATA_WIDTH-1:0] fwd_data;

   // Result producers / register-file observers
   modport master (
      output ex_valid, ex_rd_addr, ex_data, ex_word,
      output mem_valid, mem_rd_addr, mem_data, mem_size, mem_unsigned, mem_byte_off,
      input  ex_ready, mem_ready,
      input  rf_rd_addr, rf_rd_en, rf_rd_data,
      input  fwd_valid, fwd_addr, fwd_data
   );

   // Writeback stage
   modport slave (
      input  ex_valid, ex_rd_addr, ex_data, ex_word,
      input  mem_valid, mem_rd_addr, mem_data, mem_size, mem_unsigned, mem_byte_off,
      output ex_ready, mem_ready,
      output rf_rd_addr, rf_rd_en, rf_rd_data,
      output fwd_valid, fwd_addr, fwd_data
   );
endinterface
`default_nettype wire

// File: rtl/cprv_writeback.sv
`default_nettype none
// ============================================================================
// Module   : cprv_writeback
// Purpose  : Writeback stage - arbitrates execute vs load results, formats
//            load lanes and W-op results, drives the register-file write
//            port and the forwarding bus from one output register.
// Revision : 1.0 - initial release
// ============================================================================
module cprv_writeback #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int MAX_STREAK = 2
) (
   input  logic             clk,
   input  logic             rst,
   cprv_writeback_if.slave  wb
);
   localparam int               c_STREAK_W   = 2;
   localparam [c_STREAK_W-1:0]  c_STREAK_MAX = c_STREAK_W'(MAX_STREAK);

   logic [c_STREAK_W-1:0] streak_q, streak_d;
   logic                  rf_en_q, rf_en_d;
   logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;

   logic                  ex_grant;
   logic                  mem_grant;
   logic [DATA_WIDTH-1:0] lane;
   logic                  sext;
   logic [DATA_WIDTH-1:0] load_fmt;
   logic [DATA_WIDTH-1:0] ex_fmt;
   logic                  mem_aligned;

   // Loads win unless the execute side has already waited out its streak.
   // Both grants are forced low during reset so nothing is consumed then.
   assign ex_grant  = !rst && wb.ex_valid && (!wb.mem_valid || streak_q == c_STREAK_MAX);
   assign mem_grant = !rst && wb.mem_valid && !ex_grant;

   assign wb.ex_ready  = ex_grant;
   assign wb.mem_ready = mem_grant;

   // Forwarding taps the output register directly, no extra stage.
   assign wb.rf_rd_en   = rf_en_q;
   assign wb.rf_rd_addr = rf_addr_q;
   assign wb.rf_rd_data = rf_data_q;
   assign wb.fwd_valid  = rf_en_q;
   assign wb.fwd_addr   = rf_addr_q;
   assign wb.fwd_data   = rf_data_q;

   assign ex_fmt = wb.ex_word ? {{(DATA_WIDTH-32){wb.ex_data[31]}}, wb.ex_data[31:0]}
                              : wb.ex_data;

   // Load lane select and sign/zero extension; D-size ignores mem_unsigned.
   always_comb begin
      lane        = wb.mem_data >> {wb.mem_byte_off, 3'b000};
      sext        = !wb.mem_unsigned;
      load_fmt    = lane;
      mem_aligned = 1'b1;
      case (wb.mem_size)
         2'd0: begin
            load_fmt    = {{(DATA_WIDTH-8){sext & lane[7]}}, lane[7:0]};
         end
         2'd1: begin
            load_fmt    = {{(DATA_WIDTH-16){sext & lane[15]}}, lane[15:0]};
            mem_aligned = (wb.mem_byte_off[0] == 1'b0);
         end
         2'd2: begin
            load_fmt    = {{(DATA_WIDTH-32){sext & lane[31]}}, lane[31:0]};
            mem_aligned = (wb.mem_byte_off[1:0] == 2'b00);
         end
         default: begin
            load_fmt    = lane;
            mem_aligned = (wb.mem_byte_off == 3'b000);
         end
      endcase
   end

   // Next state: output register loads the granted result, x0 never writes.
   always_comb begin
      rf_en_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      streak_d  = streak_q;
      if (ex_grant) begin
         rf_en_d   = (wb.ex_rd_addr != '0);
         rf_addr_d = wb.ex_rd_addr;
         rf_data_d = ex_fmt;
      end else if (mem_grant) begin
         rf_en_d   = (wb.mem_rd_addr != '0);
         rf_addr_d = wb.mem_rd_addr;
         rf_data_d = load_fmt;
      end
      if (!wb.ex_valid || ex_grant) begin
         streak_d = '0;
      end else if (mem_grant && streak_q != c_STREAK_MAX) begin
         streak_d = streak_q + c_STREAK_W'(1);
      end
   end

   // Output register and streak counter; reset drops any held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_en_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         streak_q  <= '0;
      end else begin
         rf_en_q   <= rf_en_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         streak_q  <= streak_d;
      end
   end

   // A granted load must be naturally aligned to its size.
   always_ff @(posedge clk) begin
      if (!rst && mem_grant) begin
         assert (mem_aligned);
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_cprv_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_cprv_writeback
// Purpose  : Scoreboard bench for cprv_writeback: directed cases followed by
//            random traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cprv_writeback;
   localparam int MAX_STREAK = 2;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      bit          word;
      bit          has_exp;
      logic [63:0] expv;
   } ex_item_t;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      logic [1:0]  size;
      bit          uns;
      logic [2:0]  off;
      bit          has_exp;
      logic [63:0] expv;
   } mem_item_t;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cprv_writeback_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

   cprv_writeback #(
      .DATA_WIDTH (64),
      .ADDR_WIDTH (5),
      .MAX_STREAK (MAX_STREAK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   always #5 clk = ~clk;

   int        vectors     = 0;
   int        miscompares = 0;
   wr_t       sb_q[$];
   ex_item_t  ex_it;
   mem_item_t mem_it;
   bit        ex_pend  = 1'b0;
   bit        mem_pend = 1'b0;
   int        streak_m = 0;
   logic [1:0] obs_grant;

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_ex(ex_item_t it);
      if (it.word) return 64'(longint'(int'(it.data[31:0])));
      return it.data;
   endfunction

   function automatic logic [63:0] ref_load(mem_item_t it);
      logic [63:0] lane;
      lane = it.data >> (8 * int'(it.off));
      case (it.size)
         2'd0:    return it.uns ? 64'(lane[7:0])  : 64'(longint'(byte'(lane[7:0])));
         2'd1:    return it.uns ? 64'(lane[15:0]) : 64'(longint'(shortint'(lane[15:0])));
         2'd2:    return it.uns ? 64'(lane[31:0]) : 64'(longint'(int'(lane[31:0])));
         default: return lane;
      endcase
   endfunction

   function automatic ex_item_t rand_ex();
      ex_item_t it;
      it.rd      = 5'($urandom_range(0, 31));
      it.data    = {$urandom, $urandom};
      it.word    = 1'($urandom_range(0, 1));
      it.has_exp = 1'b0;
      it.expv    = '0;
      return it;
   endfunction

   function automatic mem_item_t rand_mem();
      mem_item_t it;
      int sz;
      sz         = $urandom_range(0, 3);
      it.rd      = 5'($urandom_range(0, 31));
      it.data    = {$urandom, $urandom};
      it.size    = 2'(sz);
      it.uns     = 1'($urandom_range(0, 1));
      it.off     = 3'($urandom_range(0, 7) & ~((1 << sz) - 1));
      it.has_exp = 1'b0;
      it.expv    = '0;
      return it;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
      end
   endtask

   // One clock: present sources, check grants against the model, log accepted
   // results into the scoreboard, then return just after the rising edge.
   task automatic step(input bit do_rst, input bit refill);
      bit ex_v, mem_v, e_exp, m_exp;
      @(negedge clk);
      rst                 = do_rst;
      bus.ex_valid        = ex_pend;
      bus.ex_rd_addr      = ex_it.rd;
      bus.ex_data         = ex_it.data;
      bus.ex_word         = ex_it.word;
      bus.mem_valid       = mem_pend;
      bus.mem_rd_addr     = mem_it.rd;
      bus.mem_data        = mem_it.data;
      bus.mem_size        = mem_it.size;
      bus.mem_unsigned    = mem_it.uns;
      bus.mem_byte_off    = mem_it.off;
      ex_v  = ex_pend;
      mem_v = mem_pend;
      #2;
      e_exp = !do_rst && ex_v && (!mem_v || streak_m >= MAX_STREAK);
      m_exp = !do_rst && mem_v && !e_exp;
      obs_grant = {bus.ex_ready, bus.mem_ready};
      chk("ex_ready",  64'(bus.ex_ready),  64'(e_exp));
      chk("mem_ready", 64'(bus.mem_ready), 64'(m_exp));
      if (e_exp) begin
         if (ex_it.rd != 0)
            sb_q.push_back('{ex_it.rd, ex_it.has_exp ? ex_it.expv : ref_ex(ex_it)});
         ex_pend = refill;
         if (refill) ex_it = rand_ex();
      end
      if (m_exp) begin
         if (mem_it.rd != 0)
            sb_q.push_back('{mem_it.rd, mem_it.has_exp ? mem_it.expv : ref_load(mem_it)});
         mem_pend = refill;
         if (refill) mem_it = rand_mem();
      end
      if (do_rst || !ex_v || e_exp) streak_m = 0;
      else if (m_exp && streak_m < MAX_STREAK) streak_m++;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every register-file write must match the oldest accepted result.
   initial begin
      wr_t w;
      forever begin
         @(posedge clk);
         #1;
         if (bus.rf_rd_en === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_write: addr %h data %h, none required", bus.rf_rd_addr, bus.rf_rd_data);
            end else begin
               w = sb_q.pop_front();
               if (bus.rf_rd_addr !== w.rd || bus.rf_rd_data !== w.data ||
                   bus.fwd_valid !== 1'b1 || bus.fwd_addr !== w.rd || bus.fwd_data !== w.data) begin
                  miscompares++;
                  $display("FAIL write: rf %h/%h fwd %b/%h/%h required %h/%h",
                           bus.rf_rd_addr, bus.rf_rd_data, bus.fwd_valid, bus.fwd_addr,
                           bus.fwd_data, w.rd, w.data);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string seq;
      logic [1:0] want_g;
      int guard;
      seq = "MMEMME";
      ex_it  = rand_ex();
      mem_it = rand_mem();

      // reset with both sources requesting
      ex_it.rd = 5'd3; mem_it.rd = 5'd4;
      ex_pend = 1'b1; mem_pend = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0);
         chk("rst_rf_en",   64'(bus.rf_rd_en),   64'd0);
         chk("rst_rf_addr", 64'(bus.rf_rd_addr), 64'd0);
         chk("rst_rf_data", bus.rf_rd_data,      64'd0);
      end
      ex_pend = 1'b0; mem_pend = 1'b0;
      step(1'b0, 1'b0);
      chk("post_rst_en",   64'(bus.rf_rd_en),   64'd0);
      chk("post_rst_addr", 64'(bus.rf_rd_addr), 64'd0);
      chk("post_rst_data", bus.rf_rd_data,      64'd0);

      // W-op sign extension
      ex_it = '{5'd5, 64'h0000_0000_8000_0001, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0001};
      ex_pend = 1'b1;
      step(1'b0, 1'b0);
      chk("ex_w_en", 64'(bus.rf_rd_en), 64'd1);

      // formatted loads
      mem_it = '{5'd7, 64'h0000_0000_8000_0000, 2'd0, 1'b0, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
      mem_pend = 1'b1;
      step(1'b0, 1'b0);
      mem_it = '{5'd8, 64'h1234_5678_9ABC_DEF0, 2'd1, 1'b1, 3'd2, 1'b1, 64'h0000_0000_0000_9ABC};
      mem_pend = 1'b1;
      step(1'b0, 1'b0);
      mem_it = '{5'd9, 64'h1234_5678_9ABC_DEF0, 2'd2, 1'b0, 3'd4, 1'b1, 64'h0000_0000_1234_5678};
      mem_pend = 1'b1;
      step(1'b0, 1'b0);

      // streak: both streams continuously valid
      ex_it = rand_ex(); mem_it = rand_mem();
      ex_pend = 1'b1; mem_pend = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1);
         want_g = (seq[i] == "E") ? 2'b10 : 2'b01;
         chk("grant_seq", 64'(obs_grant), 64'(want_g));
      end
      guard = 0;
      while ((ex_pend || mem_pend) && guard < 8) begin
         step(1'b0, 1'b0);
         guard++;
      end

      // write to x0 is accepted but never reaches the register file
      ex_it = '{5'd0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0, 64'd0};
      ex_pend = 1'b1;
      step(1'b0, 1'b0);
      chk("x0_ready", 64'(obs_grant), 64'b10);
      chk("x0_rf_en", 64'(bus.rf_rd_en), 64'd0);

      // reset in the cycle after a grant
      mem_it = rand_mem(); mem_it.rd = 5'd11;
      mem_pend = 1'b1;
      step(1'b0, 1'b0);
      ex_it = rand_ex(); ex_it.rd = 5'd12;
      ex_pend = 1'b1;
      step(1'b1, 1'b0);
      chk("midrst_rf_en", 64'(bus.rf_rd_en), 64'd0);
      step(1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (!ex_pend && $urandom_range(0, 2) != 0) begin
            ex_it = rand_ex(); ex_pend = 1'b1;
         end
         if (!mem_pend && $urandom_range(0, 2) != 0) begin
            mem_it = rand_mem(); mem_pend = 1'b1;
         end
         step(1'b0, 1'b0);
      end

      // drain
      guard = 0;
      while ((ex_pend || mem_pend) && guard < 30) begin
         step(1'b0, 1'b0);
         guard++;
      end
      chk("drain_sources", 64'(ex_pend || mem_pend), 64'd0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/cprv_writeback.md
Name: cprv_writeback

Overview:
Writeback stage of the cprv64g integer pipeline. It sits directly upstream of the register file and drives its single write port (rd_addr/rd_en/rd_data). It arbitrates between the execute result stream and the load result stream, and formats load data (lane select, sign/zero extend) and RV64 W-op results. It also exports a same-cycle forwarding bus for the decode/operand stage.

Parameters:
DATA_WIDTH, 64, register/data width in bits
ADDR_WIDTH, 5, register index width
MAX_STREAK, 2, max consecutive load grants while an execute result is waiting (1..3)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
ex_valid  input  1  execute result valid
ex_ready  output  1  execute result accepted this cycle
ex_rd_addr  input  ADDR_WIDTH  destination register
ex_data  input  DATA_WIDTH  execute result
ex_word  input  1  W-op: sign-extend ex_data[31:0] to 64 bits
mem_valid  input  1  load result valid
mem_ready  output  1  load result accepted this cycle
mem_rd_addr  input  ADDR_WIDTH  destination register
mem_data  input  DATA_WIDTH  aligned doubleword returned by memory
mem_size  input  2  0=B, 1=H, 2=W, 3=D
mem_unsigned  input  1  zero-extend (LBU/LHU/LWU) when 1
mem_byte_off  input  3  byte offset of the access within the doubleword
rf_rd_addr  output  ADDR_WIDTH  register file write address
rf_rd_en  output  1  register file write enable
rf_rd_data  output  DATA_WIDTH  register file write data
fwd_valid  output  1  forwarding valid (equals rf_rd_en)
fwd_addr  output  ADDR_WIDTH  forwarding address (equals rf_rd_addr)
fwd_data  output  DATA_WIDTH  forwarding data (equals rf_rd_data)

Behaviour:
- Reset (synchronous, rst=1 at the clock edge): rf_rd_en=0, rf_rd_addr=0, rf_rd_data=0, streak counter=0. While rst=1, ex_ready=0 and mem_ready=0.
- Reset mid-operation: any result held in the output register is dropped. rf_rd_en=0 in the cycle after the reset edge. Sources must re-present results.
- Handshake: a transfer occurs when valid&&ready at a clock edge. Sources hold valid and payload stable until accepted. At most one grant per cycle.
- Arbitration (combinational grant):
  - Load wins by default; ex_ready = ex_valid && (!mem_valid || streak==MAX_STREAK).
  - mem_ready = mem_valid && !ex_ready.
  - ready is low whenever the corresponding valid is low.
- Streak counter:
  - Increments on a mem grant while ex_valid=1.
  - Clears on an ex grant, or in any cycle with ex_valid=0.
  - Saturates at MAX_STREAK.
- Latency: one cycle. A transfer at edge N drives rf_rd_en/addr/data from after edge N until edge N+1; the register file captures it at edge N+1.
- No-grant cycle: the next rf_rd_en=0; rf_rd_addr and rf_rd_data hold their previous values.
- x0: a granted transfer with rd_addr==0 is accepted (ready=1) but produces rf_rd_en=0.
- Load formatting:
  - lane = mem_data >> (8*mem_byte_off).
  - Keep the low 8/16/32/64 bits per mem_size, then sign-extend from the top kept bit, or zero-extend if mem_unsigned.
  - For D, mem_unsigned is ignored.
  - mem_byte_off must be naturally aligned to mem_size. A simulation assertion fires on misalignment; the data result is don't-care.
- Execute formatting: ex_word=1 gives {32{ex_data[31]}, ex_data[31:0]}; otherwise ex_data passes through unchanged.
- Forwarding: fwd_* are wired directly from the output register (no extra cycle). Decode uses them to bypass the register file's asynchronous read during the write cycle.
- Ordering: the load/execute priority is a structural choice. Program order between the two streams is the scoreboard's responsibility, not this block's.

Test Plan:
- Assert rst for 2 cycles with both valids high → ex_ready=mem_ready=0, rf_rd_en=0, rf_rd_addr=0, rf_rd_data=0 throughout and one cycle after.
- ex_valid only, rd=5, ex_data=0x0000_0000_8000_0001, ex_word=1 → ex_ready=1; next cycle rf_rd_en=1, addr=5, data=0xFFFF_FFFF_8000_0001, fwd_* identical.
- Load LB at off=3 (mem_size=0, mem_unsigned=0), rd=7, mem_data=0x0000_0000_8000_0000 → rf_rd_data=0xFFFF_FFFF_FFFF_FF80.
- Load LHU at off=2, mem_data=0x1234_5678_9ABC_DEF0 → rf_rd_data=0x0000_0000_0000_9ABC.
- Load LW at off=4, same mem_data → rf_rd_data=0x0000_0000_1234_5678.
- Both valid continuously, MAX_STREAK=2 → grant sequence mem, mem, ex, mem, mem, ex; exactly one ready high per cycle.
- ex transfer with rd=0 → ex_ready=1, rf_rd_en stays 0.
- rst asserted in the cycle after a grant → the pending write is suppressed (rf_rd_en=0).
